// File: rtl/lc3_mem_ctrl_if.sv
// Request/response and memory-bus bundle for the LC-3 memory-access sequencer.
// slave  : the sequencer's view (takes FSM requests, drives the bus and MDR).
// master : the environment's view (control FSM, memory/MMIO and MDR side).
interface lc3_mem_ctrl_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_r;
    logic                  mdr_wr_en;
    logic [DATA_WIDTH-1:0] mdr_d;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_rdata, mem_r,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_en, mem_we, mem_addr, mem_wdata, mdr_wr_en, mdr_d
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_rdata, mem_r,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_en, mem_we, mem_addr, mem_wdata, mdr_wr_en, mdr_d
    );
endinterface

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory-access sequencer: accepts one read/write, holds it on the bus
// until mem_r, then pulses a one-cycle completion (and loads MDR on reads).
// Optional macro MEM_TIMEOUT_EN: abandon a stalled access after TIMEOUT_CYCLES
// ISSUE cycles and complete with resp_err = 1.
module lc3_mem_ctrl #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    lc3_mem_ctrl_if.slave     bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_e;

    state_e                state_q, state_d;
    logic                  req_ready_q, req_ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  resp_err_q, resp_err_d;
    logic                  mem_en_q, mem_en_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic                  mdr_wr_en_q, mdr_wr_en_d;
    logic [DATA_WIDTH-1:0] mdr_d_q, mdr_d_d;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    // Timeout limit has no role when the feature is compiled out.
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
`endif

    // Next-state and next-output computation; every output is registered.
    always_comb begin
        state_d      = state_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = 1'b0;
        resp_err_d   = resp_err_q;
        mem_en_d     = mem_en_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        resp_rdata_d = resp_rdata_q;
        mdr_wr_en_d  = 1'b0;
        mdr_d_d      = mdr_d_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d        = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                // The bus registers double as the request latch.
                if (bus.req_valid && req_ready_q) begin
                    state_d     = ISSUE;
                    req_ready_d = 1'b0;
                    mem_en_d    = 1'b1;
                    mem_we_d    = bus.req_we;
                    mem_addr_d  = bus.req_addr;
                    mem_wdata_d = bus.req_wdata;
`ifdef MEM_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            ISSUE: begin
                // A ready memory always wins over a same-cycle timeout.
                if (bus.mem_r) begin
                    state_d      = DONE;
                    mem_en_d     = 1'b0;
                    mem_we_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    if (!mem_we_q) begin
                        resp_rdata_d = bus.mem_rdata;
                        mdr_wr_en_d  = 1'b1;
                        mdr_d_d      = bus.mem_rdata;
                    end
                end
`ifdef MEM_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d      = DONE;
                    mem_en_d     = 1'b0;
                    mem_we_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                end else if (cnt_q != CNT_W'(TIMEOUT_CYCLES)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            DONE: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                mem_en_d    = 1'b0;
                mem_we_d    = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            resp_rdata_q <= '0;
            mdr_wr_en_q  <= 1'b0;
            mdr_d_q      <= '0;
`ifdef MEM_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_rdata_q <= resp_rdata_d;
            mdr_wr_en_q  <= mdr_wr_en_d;
            mdr_d_q      <= mdr_d_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.mem_en     = mem_en_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mdr_wr_en  = mdr_wr_en_q;
    assign bus.mdr_d      = mdr_d_q;
endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Directed bench for lc3_mem_ctrl with hand-computed expectations.
module tb_lc3_mem_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    lc3_mem_ctrl_if bus ();

    lc3_mem_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .TIMEOUT_CYCLES(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".req_ready"},  bus.req_ready, 1);
        chk({tag, ".mem_en"},     bus.mem_en, 0);
        chk({tag, ".mem_we"},     bus.mem_we, 0);
        chk({tag, ".resp_valid"}, bus.resp_valid, 0);
        chk({tag, ".mdr_wr_en"},  bus.mdr_wr_en, 0);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.mem_rdata = '0;
        bus.mem_r     = 1'b0;

        // Reset state
        step();
        step();
        chk_idle("rst");
        chk("rst.resp_err",   bus.resp_err, 0);
        chk("rst.mem_addr",   bus.mem_addr, 0);
        chk("rst.mem_wdata",  bus.mem_wdata, 0);
        chk("rst.resp_rdata", bus.resp_rdata, 0);
        chk("rst.mdr_d",      bus.mdr_d, 0);
        rst_n = 1'b1;
        step();
        chk_idle("post_rst");

        // Read, zero wait
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 16'h0040;
        bus.mem_rdata = 16'h1234;
        bus.mem_r     = 1'b1;
        step();  // accept
        bus.req_valid = 1'b0;
        chk("rd0.issue.mem_en",    bus.mem_en, 1);
        chk("rd0.issue.mem_we",    bus.mem_we, 0);
        chk("rd0.issue.mem_addr",  bus.mem_addr, 16'h0040);
        chk("rd0.issue.req_ready", bus.req_ready, 0);
        chk("rd0.issue.resp_valid", bus.resp_valid, 0);
        step();  // DONE
        bus.mem_r = 1'b0;
        chk("rd0.done.resp_valid", bus.resp_valid, 1);
        chk("rd0.done.mdr_wr_en",  bus.mdr_wr_en, 1);
        chk("rd0.done.mdr_d",      bus.mdr_d, 16'h1234);
        chk("rd0.done.resp_rdata", bus.resp_rdata, 16'h1234);
        chk("rd0.done.resp_err",   bus.resp_err, 0);
        chk("rd0.done.mem_en",     bus.mem_en, 0);
        chk("rd0.done.req_ready",  bus.req_ready, 0);
        step();
        chk_idle("rd0.idle");
        chk("rd0.idle.resp_rdata", bus.resp_rdata, 16'h1234);

        // Write, 3 wait cycles; a competing request is held during ISSUE
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 16'h3000;
        bus.req_wdata = 16'hBEEF;
        bus.mem_rdata = 16'h5555;
        step();  // accept
        bus.req_we    = 1'b0;
        bus.req_addr  = 16'hFE00;
        bus.req_wdata = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wr.issue%0d.mem_en", i),    bus.mem_en, 1);
            chk($sformatf("wr.issue%0d.mem_we", i),    bus.mem_we, 1);
            chk($sformatf("wr.issue%0d.mem_addr", i),  bus.mem_addr, 16'h3000);
            chk($sformatf("wr.issue%0d.mem_wdata", i), bus.mem_wdata, 16'hBEEF);
            chk($sformatf("wr.issue%0d.req_ready", i), bus.req_ready, 0);
            chk($sformatf("wr.issue%0d.resp_valid", i), bus.resp_valid, 0);
            if (i == 3) bus.mem_r = 1'b1;
            step();
        end
        bus.mem_r = 1'b0;
        chk("wr.done.resp_valid", bus.resp_valid, 1);
        chk("wr.done.mdr_wr_en",  bus.mdr_wr_en, 0);
        chk("wr.done.resp_rdata", bus.resp_rdata, 16'h1234);
        chk("wr.done.mem_en",     bus.mem_en, 0);
        step();  // back to IDLE; held request not yet accepted
        chk_idle("wr.idle");
        chk("wr.idle.mdr_d", bus.mdr_d, 16'h1234);
        step();  // held FE00 read accepted now
        bus.req_valid = 1'b0;
        chk("hold.issue.mem_en",   bus.mem_en, 1);
        chk("hold.issue.mem_we",   bus.mem_we, 0);
        chk("hold.issue.mem_addr", bus.mem_addr, 16'hFE00);

        // Reset during ISSUE of a read, with mem_r arriving at the same edge
        bus.mem_rdata = 16'hAAAA;
        bus.mem_r     = 1'b1;
        rst_n         = 1'b0;
        step();
        chk_idle("rstmid");
        chk("rstmid.resp_rdata", bus.resp_rdata, 0);
        chk("rstmid.mdr_d",      bus.mdr_d, 0);
        bus.mem_r = 1'b0;
        rst_n     = 1'b1;
        step();
        chk_idle("rstmid.rel0");
        step();
        chk_idle("rstmid.rel1");

        // mem_r pulsed while IDLE has no effect
        for (int i = 0; i < 3; i++) begin
            bus.mem_r = (i != 1);
            step();
            chk_idle($sformatf("idle_memr%0d", i));
            chk($sformatf("idle_memr%0d.mem_addr", i), bus.mem_addr, 0);
        end
        bus.mem_r = 1'b0;
        step();

`ifdef MEM_TIMEOUT_EN
        // Timeout: mem_r held low for exactly TIMEOUT_CYCLES ISSUE cycles
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 16'h4000;
        bus.mem_rdata = 16'h0BAD;
        step();
        bus.req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("to.issue%0d.mem_en", i),    bus.mem_en, 1);
            chk($sformatf("to.issue%0d.resp_valid", i), bus.resp_valid, 0);
            step();
        end
        chk("to.done.resp_valid", bus.resp_valid, 1);
        chk("to.done.resp_err",   bus.resp_err, 1);
        chk("to.done.mdr_wr_en",  bus.mdr_wr_en, 0);
        chk("to.done.mem_en",     bus.mem_en, 0);
        step();
        chk_idle("to.idle");
        chk("to.idle.resp_err", bus.resp_err, 1);

        // mem_r on the 4th ISSUE cycle beats the timeout
        bus.req_valid = 1'b1;
        bus.mem_rdata = 16'h5A5A;
        step();
        bus.req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("tor.issue%0d.mem_en", i), bus.mem_en, 1);
            if (i == 3) bus.mem_r = 1'b1;
            step();
        end
        bus.mem_r = 1'b0;
        chk("tor.done.resp_valid", bus.resp_valid, 1);
        chk("tor.done.resp_err",   bus.resp_err, 0);
        chk("tor.done.mdr_wr_en",  bus.mdr_wr_en, 1);
        chk("tor.done.mdr_d",      bus.mdr_d, 16'h5A5A);
        step();
`else
        // No timeout: a long stall keeps the access on the bus
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 16'h4000;
        bus.mem_rdata = 16'h5A5A;
        step();
        bus.req_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("stall%0d.mem_en", i),     bus.mem_en, 1);
            chk($sformatf("stall%0d.resp_valid", i), bus.resp_valid, 0);
            step();
        end
        bus.mem_r = 1'b1;
        step();
        bus.mem_r = 1'b0;
        chk("stall.done.resp_valid", bus.resp_valid, 1);
        chk("stall.done.resp_err",   bus.resp_err, 0);
        chk("stall.done.mdr_d",      bus.mdr_d, 16'h5A5A);
        step();
`endif
        chk_idle("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
